// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus transmit/receive byte handshake for spi_slave.
// Signals:
//   sclk, cs, mosi  SPI inputs from the master (cs active low, sclk idles low).
//   miso            SPI serial data back to the master.
//   tx_data/tx_load byte and write strobe for the transmit buffer.
//   tx_ready        transmit buffer empty.
//   rx_data/rx_valid last received byte and its one-cycle completion pulse.
//   tx_underrun     one-cycle pulse when the idle byte is substituted.
// Modports: slave (the spi_slave block), master (the driving side).
interface spi_slave_if;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun
    );

    modport master (
        output sclk, cs, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 MSB-first SPI responder, oversampled in the local clock domain.
// Ports:
//   clk_i   local clock, at least 8x the SPI clock.
//   rst_ni  asynchronous active-low reset.
//   bus     spi_slave_if.slave: SPI pins, one-byte transmit buffer, receive byte/pulse.
// Parameters: SYNC_STAGES synchroniser depth (>= 2), IDLE_BYTE sent when the buffer is empty.
// Macro SPI_SLAVE_UNDERRUN_EN enables the tx_underrun pulse; otherwise it is tied low.
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input logic        clk_i,
    input logic        rst_ni,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   boundary_q, boundary_d;
    logic [7:0]             buf_q, buf_d;
    logic                   full_q, full_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   reload, shift_out, rx_step, load_ok;
    logic                   miso;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;

    // cs_rise takes priority over any SCLK activity in the same cycle.
    assign reload    = !cs_rise && ((state_q == IDLE && cs_fall) ||
                                    (state_q == ACTIVE && sclk_fall && boundary_q));
    assign shift_out = !cs_rise && state_q == ACTIVE && sclk_fall && !boundary_q;
    assign rx_step   = !cs_rise && state_q == ACTIVE && sclk_rise;
    assign load_ok   = bus.tx_load && !full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) state_d = IDLE;
        else if (state_q == IDLE && cs_fall) state_d = ACTIVE;
    end

    always_comb begin
        miso = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b0;
    end

    // Datapath next state. A same-cycle load sees an empty buffer, so the
    // reload takes IDLE_BYTE and the new byte stays buffered.
    always_comb begin
        tx_shift_d = reload ? (full_q ? buf_q : IDLE_BYTE) :
                     shift_out ? {tx_shift_q[6:0], 1'b0} : tx_shift_q;
        buf_d      = load_ok ? bus.tx_data : buf_q;
        full_d     = load_ok ? 1'b1 : reload ? 1'b0 : full_q;
        rx_shift_d = rx_step ? {rx_shift_q[5:0], mosi_s} : rx_shift_q;
        cnt_d      = cs_rise ? 3'd0 : rx_step ? cnt_q + 3'd1 : cnt_q;
        rx_valid_d = rx_step && cnt_q == 3'd7;
        rx_data_d  = rx_valid_d ? {rx_shift_q, mosi_s} : rx_data_q;
        boundary_d = cs_rise ? 1'b0 : rx_valid_d ? 1'b1 :
                     (state_q == ACTIVE && sclk_fall) ? 1'b0 : boundary_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
            boundary_q  <= 1'b0;
            buf_q       <= '0;
            full_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            cnt_q       <= cnt_d;
            boundary_q  <= boundary_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= reload && !full_q;
        end
    end

    assign bus.tx_underrun = underrun_q;
`else
    assign bus.tx_underrun = 1'b0;
`endif

    assign bus.miso     = miso;
    assign bus.tx_ready = ~full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bit-banged SPI master with scoreboard queues for received and returned bytes.
module tb_spi_slave;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'h00)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int rx_pulses = 0;
    int ur_pulses = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] miso_exp[$];
    logic [7:0] rx_e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            rx_pulses++;
            checks++;
            if (rx_exp.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got rx_data=%h, expected no byte", bus.rx_data);
            end else begin
                rx_e = rx_exp.pop_front();
                if (bus.rx_data !== rx_e) begin
                    errors++;
                    $display("FAIL rx_data: got %h, expected %h", bus.rx_data, rx_e);
                end
            end
            checks++;
            if (cyc - rise_cyc !== SYNC + 1) begin
                errors++;
                $display("FAIL rx_latency: got %0d cycles, expected %0d", cyc - rise_cyc, SYNC + 1);
            end
        end
        if (bus.tx_underrun === 1'b1) ur_pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
    endtask

    task automatic cs_low();
        bus.cs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        bus.cs = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic xfer(input logic [7:0] m, input int nbits, output logic [7:0] s);
        s = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = m[i];
            tick(HALF);
            bus.sclk = 1'b1;
            rise_cyc = cyc;
            s[i] = bus.miso;
            tick(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks++;
        if ({bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got miso=%b rdy=%b rx=%h vld=%b ur=%b, expected 0 1 00 0 0",
                     bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_basic();
        logic [7:0] got, e;
        rx_pulses = 0;
        load(8'hA5);
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_after_load: got %b, expected 0", bus.tx_ready);
        end
        rx_exp.push_back(8'h3C);
        miso_exp.push_back(8'hA5);
        bus.cs = 1'b0;
        tick(2);
        checks++;
        if (bus.miso !== 1'b0) begin
            errors++;
            $display("FAIL basic_miso_early: got %b, expected 0", bus.miso);
        end
        tick(1);
        checks++;
        if (bus.miso !== 1'b1) begin
            errors++;
            $display("FAIL basic_miso_msb: got %b, expected 1", bus.miso);
        end
        tick(HALF - 3);
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_after_cs: got %b, expected 1", bus.tx_ready);
        end
        xfer(8'h3C, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL basic_miso_byte: got %h, expected %h", got, e);
        end
        cs_high();
        checks++;
        if (rx_pulses !== 1 || bus.rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_rx: got pulses=%0d rx=%h, expected 1 3c", rx_pulses, bus.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e;
        rx_pulses = 0;
        load(8'hA5);
        rx_exp.push_back(8'h12);
        rx_exp.push_back(8'h34);
        miso_exp.push_back(8'hA5);
        miso_exp.push_back(8'h5A);
        cs_low();
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b, expected 1", bus.tx_ready);
        end
        load(8'h5A);
        xfer(8'h12, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL b2b_miso_first: got %h, expected %h", got, e);
        end
        xfer(8'h34, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL b2b_miso_second: got %h, expected %h", got, e);
        end
        cs_high();
        checks++;
        if (rx_pulses !== 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, expected 2", rx_pulses);
        end
    endtask

    task automatic test_partial();
        logic [7:0] got, e;
        rx_pulses = 0;
        cs_low();
        xfer(8'hFF, 5, got);
        cs_high();
        checks++;
        if (rx_pulses !== 0 || bus.rx_data !== 8'h34) begin
            errors++;
            $display("FAIL partial_discard: got pulses=%0d rx=%h, expected 0 34", rx_pulses, bus.rx_data);
        end
        rx_exp.push_back(8'h81);
        miso_exp.push_back(8'h00);
        cs_low();
        xfer(8'h81, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL partial_idle_byte: got %h, expected %h", got, e);
        end
        cs_high();
        checks++;
        if (rx_pulses !== 1 || bus.rx_data !== 8'h81) begin
            errors++;
            $display("FAIL partial_next_frame: got pulses=%0d rx=%h, expected 1 81", rx_pulses, bus.rx_data);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] got, e;
        int exp_ur;
`ifdef SPI_SLAVE_UNDERRUN_EN
        exp_ur = 1;
`else
        exp_ur = 0;
`endif
        ur_pulses = 0;
        rx_exp.push_back(8'hC3);
        miso_exp.push_back(8'h00);
        cs_low();
        checks++;
        if (ur_pulses !== exp_ur) begin
            errors++;
            $display("FAIL underrun_pulses: got %0d, expected %0d", ur_pulses, exp_ur);
        end
        xfer(8'hC3, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL underrun_miso: got %h, expected %h", got, e);
        end
        cs_high();
    endtask

    task automatic test_load_ignored();
        logic [7:0] got, e;
        load(8'h77);
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignored_ready: got %b, expected 0", bus.tx_ready);
        end
        load(8'hEE);
        rx_exp.push_back(8'h96);
        miso_exp.push_back(8'h77);
        cs_low();
        xfer(8'h96, 8, got);
        e = miso_exp.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL ignored_miso: got %h, expected %h", got, e);
        end
        cs_high();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        load(8'h77);
        cs_low();
        xfer(8'hFF, 3, got);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midframe_reset: got miso=%b rdy=%b rx=%h vld=%b ur=%b, expected 0 1 00 0 0",
                     bus.miso, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun);
        end
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        checks++;
        if (bus.tx_ready !== 1'b1 || bus.miso !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got rdy=%b miso=%b, expected 1 0", bus.tx_ready, bus.miso);
        end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_underrun();
        test_load_ignored();
        test_reset_mid_frame();
        checks++;
        if (rx_exp.size() != 0 || miso_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got rx=%0d miso=%0d left, expected 0 0", rx_exp.size(), miso_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
